// File: rtl/accel_axi_mst.sv
// accel_axi_mst: single-outstanding AXI4 initiator for one bus0 master slot.
// A simple request/write-beat/response interface is turned into AR/R or
// AW/W/B bursts. Reads and writes are serialized.
// Optional build macro ACCEL_AXI_MST_4K_CHECK_EN: bursts that would cross a
// 4 KiB boundary are answered locally with error responses and never reach
// the fabric.

package accel_axi_mst_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS  = 32;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
    localparam int CFG_SYSBUS_ID_BITS    = 5;
    localparam int CFG_SYSBUS_USER_BITS  = 1;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    typedef struct packed {
        logic                             aw_valid;
        axi4_metadata_type                aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_metadata_type                ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                             aw_ready;
        logic                             w_ready;
        logic                             b_valid;
        logic [1:0]                       b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
        logic                             ar_ready;
        logic                             r_valid;
        logic [1:0]                       r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
        logic                             r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
    } axi4_master_in_type;

    localparam axi4_master_out_type axi4_master_out_none = '0;

endpackage

module accel_axi_mst
    import accel_axi_mst_pkg::*;
#(
    parameter logic [CFG_SYSBUS_ID_BITS-1:0] xid        = '0,
    parameter logic [1:0]                    burst_type = 2'b01
) (
    input  logic                             i_clk,
    input  logic                             i_nrst,
    input  axi4_master_in_type               i_xmsti,
    output axi4_master_out_type              o_xmsto,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_write,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
    input  logic [7:0]                       i_req_len,
    input  logic [2:0]                       i_req_size,
    input  logic                             i_wdata_valid,
    output logic                             o_wdata_ready,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_wstrb,
    output logic                             o_resp_valid,
    input  logic                             i_resp_ready,
    output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
    output logic                             o_resp_last,
    output logic                             o_resp_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_ERR
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] req_addr;
    logic [7:0]                      req_len;
    logic [2:0]                      req_size;
    logic                            req_write;
    logic [7:0]                      beat_cnt;
    logic                            accept;
    logic                            cnt_inc;
    logic                            beat_last;
    logic                            unused_in;

    assign beat_last = (beat_cnt == req_len);
    assign unused_in = ^{i_xmsti.b_id, i_xmsti.b_user, i_xmsti.r_id, i_xmsti.r_user};

`ifdef ACCEL_AXI_MST_4K_CHECK_EN
    localparam int AW1 = CFG_SYSBUS_ADDR_BITS + 1;

    logic [AW1-1:0] span_bytes;
    logic [AW1-1:0] span_end;
    logic           cross_4k;
    logic           err_rsp;
    logic           err_rsp_set;
    logic           unused_span;

    // Last byte of the requested burst, one bit wider than the address
    always_comb begin
        span_bytes = (AW1'(i_req_len) + AW1'(1)) << i_req_size;
        span_end   = {1'b0, i_req_addr} + span_bytes - AW1'(1);
        cross_4k   = (span_end[CFG_SYSBUS_ADDR_BITS-1:12] != i_req_addr[CFG_SYSBUS_ADDR_BITS-1:12]);
    end

    assign unused_span = ^{span_end[AW1-1], span_end[11:0]};

    // Local-error write: data phase finished, response phase pending
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            err_rsp <= 1'b0;
        end else if (accept) begin
            err_rsp <= 1'b0;
        end else if (err_rsp_set) begin
            err_rsp <= 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture and beat counter
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            req_addr  <= '0;
            req_len   <= '0;
            req_size  <= '0;
            req_write <= 1'b0;
            beat_cnt  <= '0;
        end else if (accept) begin
            req_addr  <= i_req_addr;
            req_len   <= i_req_len;
            req_size  <= i_req_size;
            req_write <= i_req_write;
            beat_cnt  <= '0;
        end else if (cnt_inc) begin
            beat_cnt  <= beat_cnt + 8'd1;
        end
    end

    // Next-state and all channel outputs
    always_comb begin
        state_nxt     = state;
        o_xmsto       = axi4_master_out_none;
        o_req_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        o_resp_valid  = 1'b0;
        o_resp_rdata  = '0;
        o_resp_last   = 1'b0;
        o_resp_err    = 1'b0;
        accept        = 1'b0;
        cnt_inc       = 1'b0;
`ifdef ACCEL_AXI_MST_4K_CHECK_EN
        err_rsp_set   = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    accept = 1'b1;
`ifdef ACCEL_AXI_MST_4K_CHECK_EN
                    if (cross_4k) begin
                        state_nxt = ST_ERR;
                    end else
`endif
                    if (i_req_write) begin
                        state_nxt = ST_AW;
                    end else begin
                        state_nxt = ST_AR;
                    end
                end
            end

            ST_AR: begin
                o_xmsto.ar_valid      = 1'b1;
                o_xmsto.ar_bits.addr  = req_addr;
                o_xmsto.ar_bits.len   = req_len;
                o_xmsto.ar_bits.size  = req_size;
                o_xmsto.ar_bits.burst = burst_type;
                o_xmsto.ar_id         = xid;
                if (i_xmsti.ar_ready) begin
                    state_nxt = ST_R;
                end
            end

            ST_R: begin
                o_xmsto.r_ready = i_resp_ready;
                o_resp_valid    = i_xmsti.r_valid;
                o_resp_rdata    = i_xmsti.r_data;
                o_resp_last     = i_xmsti.r_last;
                o_resp_err      = i_xmsti.r_resp[1];
                if (i_xmsti.r_valid && i_resp_ready && i_xmsti.r_last) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_AW: begin
                o_xmsto.aw_valid      = 1'b1;
                o_xmsto.aw_bits.addr  = req_addr;
                o_xmsto.aw_bits.len   = req_len;
                o_xmsto.aw_bits.size  = req_size;
                o_xmsto.aw_bits.burst = burst_type;
                o_xmsto.aw_id         = xid;
                if (i_xmsti.aw_ready) begin
                    state_nxt = ST_W;
                end
            end

            ST_W: begin
                o_xmsto.w_valid = i_wdata_valid;
                o_xmsto.w_data  = i_wdata;
                o_xmsto.w_strb  = i_wstrb;
                o_xmsto.w_last  = beat_last;
                o_wdata_ready   = i_xmsti.w_ready;
                if (i_wdata_valid && i_xmsti.w_ready) begin
                    if (beat_last) begin
                        state_nxt = ST_B;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_B: begin
                o_xmsto.b_ready = i_resp_ready;
                o_resp_valid    = i_xmsti.b_valid;
                o_resp_last     = 1'b1;
                o_resp_err      = i_xmsti.b_resp[1];
                if (i_xmsti.b_valid && i_resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_ERR: begin
`ifdef ACCEL_AXI_MST_4K_CHECK_EN
                // Reads: len+1 error beats. Writes: drain len+1 beats, then one error response.
                if (!req_write) begin
                    o_resp_valid = 1'b1;
                    o_resp_rdata = '1;
                    o_resp_last  = beat_last;
                    o_resp_err   = 1'b1;
                    if (i_resp_ready) begin
                        if (beat_last) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end else if (!err_rsp) begin
                    o_wdata_ready = 1'b1;
                    if (i_wdata_valid) begin
                        if (beat_last) begin
                            err_rsp_set = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end else begin
                    o_resp_valid = 1'b1;
                    o_resp_last  = 1'b1;
                    o_resp_err   = 1'b1;
                    if (i_resp_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
`else
                state_nxt = ST_IDLE;
`endif
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_accel_axi_mst.sv
// tb_accel_axi_mst: table-driven and randomized bench for accel_axi_mst.
// The bench acts as both requester and AXI slave; a transaction-level model
// predicts every response beat. Honours ACCEL_AXI_MST_4K_CHECK_EN.

module tb_accel_axi_mst;
    import accel_axi_mst_pkg::*;

    localparam logic [CFG_SYSBUS_ID_BITS-1:0] XID = 5'd3;
`ifdef ACCEL_AXI_MST_4K_CHECK_EN
    localparam bit CHK4K = 1'b1;
`else
    localparam bit CHK4K = 1'b0;
`endif

    logic                             clk = 1'b0;
    logic                             nrst;
    axi4_master_in_type               xmsti;
    axi4_master_out_type              xmsto;
    logic                             req_valid;
    logic                             req_ready;
    logic                             req_write;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  req_addr;
    logic [7:0]                       req_len;
    logic [2:0]                       req_size;
    logic                             wdata_valid;
    logic                             wdata_ready;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb;
    logic                             resp_valid;
    logic                             resp_ready;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  resp_rdata;
    logic                             resp_last;
    logic                             resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    accel_axi_mst #(.xid(XID), .burst_type(2'b01)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_xmsti(xmsti), .o_xmsto(xmsto),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready),
        .i_wdata(wdata), .i_wstrb(wstrb),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata), .o_resp_last(resp_last), .o_resp_err(resp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rdat(input logic [31:0] a, input int b);
        return {a, 32'(b) ^ 32'hA5A5_0000};
    endfunction

    function automatic logic [63:0] wdat(input int b);
        return {32'hC0DE_0000 | 32'(b), ~32'(b)};
    endfunction

    function automatic logic [7:0] wstb(input int b);
        return 8'(b * 37 + 1);
    endfunction

    // Burst touches two 4 KiB pages and the check is built in
    function automatic bit local_err(input logic [31:0] a, input int len, input int size);
        longint unsigned e;
        longint unsigned s;
        s = 64'(a);
        e = s + (64'(len + 1) << size) - 64'd1;
        return CHK4K && (e[31:12] != s[31:12]);
    endfunction

    task automatic idle_inputs();
        xmsti       = '0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        req_size    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        resp_ready  = 1'b0;
    endtask

    // One complete transaction: requester, slave and response checker in lockstep.
    // Inputs are driven at negedge; handshakes are judged 1 time unit later.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] resp, input int err_beat, input int aw_delay,
                           input int gap, input int bp, input int abort_w,
                           output int axi_seen, output int nresp, output int nerr);
        logic [63:0] e_data[$];
        bit          e_last[$];
        bit          e_err[$];
        bit          lerr;
        bit          req_done = 0, addr_done = 0, b_done = 0, rv = 0, wv = 0, bv = 0, done = 0;
        int          ar_hi = 0, rb = 0, wb_drv = 0, wb_slv = 0, cyc = 0, wviol = 0, rrviol = 0;

        axi_seen = 0;
        nresp    = 0;
        nerr     = 0;
        lerr     = local_err(addr, len, size);
        if (!wr) begin
            for (int b = 0; b <= len; b++) begin
                e_data.push_back(lerr ? '1 : rdat(addr, b));
                e_last.push_back(b == len);
                e_err.push_back(lerr ? 1'b1 : ((b == err_beat) && resp[1]));
            end
        end else begin
            e_data.push_back('0);
            e_last.push_back(1'b1);
            e_err.push_back(lerr ? 1'b1 : resp[1]);
        end

        while (!done) begin
            @(negedge clk);
            req_valid = !req_done;
            req_write = wr;
            req_addr  = addr;
            req_len   = 8'(len);
            req_size  = 3'(size);
            xmsti     = '0;
            xmsti.ar_ready = (ar_hi >= aw_delay);
            xmsti.aw_ready = (ar_hi >= aw_delay);
            if (!rv) rv = addr_done && !wr && (rb <= len) && (gap == 0 || $urandom_range(0, 2) != 0);
            xmsti.r_valid = rv;
            xmsti.r_data  = rdat(addr, rb);
            xmsti.r_last  = (rb == len);
            xmsti.r_resp  = (rb == err_beat) ? resp : 2'b00;
            xmsti.r_id    = XID;
            if (!wv) wv = wr && (wb_drv <= len) && (gap == 0 || $urandom_range(0, 2) != 0);
            wdata_valid   = wv;
            wdata         = wdat(wb_drv);
            wstrb         = wstb(wb_drv);
            xmsti.w_ready = (gap == 0) || ($urandom_range(0, 3) != 0);
            bv = addr_done && wr && (wb_slv == len + 1) && !b_done;
            xmsti.b_valid = bv;
            xmsti.b_resp  = resp;
            xmsti.b_id    = XID;
            resp_ready = (bp == 0) ? 1'b1 : (bp == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            #1;

            if (!req_done && req_ready) req_done = 1;
            if (xmsto.ar_valid || xmsto.aw_valid) axi_seen = 1;
            if (!addr_done && xmsto.w_valid) wviol++;
            if (addr_done && !wr && rb <= len && xmsto.r_ready !== resp_ready) rrviol++;
            if (xmsto.ar_valid) begin
                if (xmsti.ar_ready) begin
                    chk("ar_addr", 64'(xmsto.ar_bits.addr), 64'(addr));
                    chk("ar_len", 64'(xmsto.ar_bits.len), 64'(len));
                    chk("ar_size", 64'(xmsto.ar_bits.size), 64'(size));
                    chk("ar_burst", 64'(xmsto.ar_bits.burst), 64'd1);
                    chk("ar_id", 64'(xmsto.ar_id), 64'(XID));
                    addr_done = 1;
                end else ar_hi++;
            end
            if (xmsto.aw_valid) begin
                if (xmsti.aw_ready) begin
                    chk("aw_addr", 64'(xmsto.aw_bits.addr), 64'(addr));
                    chk("aw_len", 64'(xmsto.aw_bits.len), 64'(len));
                    chk("aw_size", 64'(xmsto.aw_bits.size), 64'(size));
                    chk("aw_burst", 64'(xmsto.aw_bits.burst), 64'd1);
                    chk("aw_id", 64'(xmsto.aw_id), 64'(XID));
                    addr_done = 1;
                end else ar_hi++;
            end
            if (rv && xmsto.r_ready) begin rb++; rv = 0; end
            if (wv && wdata_ready) begin wb_drv++; wv = 0; end
            if (xmsto.w_valid && xmsti.w_ready) begin
                chk("w_data", xmsto.w_data, wdat(wb_slv));
                chk("w_strb", 64'(xmsto.w_strb), 64'(wstb(wb_slv)));
                chk("w_last", 64'(xmsto.w_last), 64'(wb_slv == len));
                wb_slv++;
            end
            if (bv && xmsto.b_ready) b_done = 1;
            if (resp_valid && resp_ready) begin
                if (nresp < e_data.size()) begin
                    chk("resp_rdata", resp_rdata, e_data[nresp]);
                    chk("resp_last", 64'(resp_last), 64'(e_last[nresp]));
                    chk("resp_err", 64'(resp_err), 64'(e_err[nresp]));
                end else begin
                    chk("resp_count", 64'(nresp + 1), 64'(e_data.size()));
                end
                nerr += int'(resp_err);
                nresp++;
                if (nresp == e_data.size()) begin
                    chk("req_ready_at_last", 64'(req_ready), 64'd0);
                    done = 1;
                end
            end
            if (abort_w >= 0 && wb_slv == abort_w) begin
                #2 nrst = 1'b0;
                #1 chk("rst_outs", 64'({xmsto.ar_valid, xmsto.aw_valid, xmsto.w_valid, xmsto.r_ready,
                                        xmsto.b_ready, resp_valid, wdata_ready, req_ready}), 64'h01);
                idle_inputs();
                @(posedge clk);
                @(negedge clk);
                nrst = 1'b1;
                return;
            end
            cyc++;
            if (cyc > 4000) begin
                chk("txn_timeout", 64'(cyc), 64'd0);
                done = 1;
            end
        end

        chk("wbeats_consumed", 64'(wb_drv), wr ? 64'(len + 1) : 64'd0);
        chk("w_before_aw", 64'(wviol), 64'd0);
        chk("r_ready_mirror", 64'(rrviol), 64'd0);
        @(negedge clk);
        idle_inputs();
        #1 chk("req_ready_after", 64'(req_ready), 64'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        int          size;
        logic [1:0]  resp;
        int          err_beat;
        int          aw_delay;
        int          gap;
        int          bp;
        int          exp_axi;
        int          exp_n;
        int          exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    initial begin
        int axi_seen, nresp, nerr;

        vt[0] = '{0, 32'h0000_1000, 3,   3, 2'b00, -1, 0, 0, 0, 1, 4, 0};
        vt[1] = '{1, 32'h0000_2008, 1,   3, 2'b00, -1, 3, 1, 0, 1, 1, 0};
        vt[2] = '{0, 32'h0000_3000, 7,   3, 2'b00, -1, 0, 0, 1, 1, 8, 0};
        vt[3] = '{1, 32'h0000_4000, 0,   3, 2'b10, -1, 1, 0, 0, 1, 1, 1};
        vt[4] = '{0, 32'h0000_5000, 3,   3, 2'b11,  2, 0, 1, 2, 1, 4, 1};
        vt[5] = '{1, 32'h0000_6000, 255, 3, 2'b00, -1, 0, 1, 2, 1, 1, 0};
        vt[8] = '{0, 32'h0000_7FFF, 0,   0, 2'b00, -1, 2, 0, 0, 1, 1, 0};
        vt[9] = '{0, 32'h0000_8000, 1,   3, 2'b01,  0, 0, 1, 1, 1, 2, 0};
`ifdef ACCEL_AXI_MST_4K_CHECK_EN
        vt[6] = '{0, 32'h0000_0FF8, 1,   3, 2'b00, -1, 0, 0, 0, 0, 2, 2};
        vt[7] = '{1, 32'h0000_1FFC, 1,   2, 2'b00, -1, 0, 1, 0, 0, 1, 1};
`else
        vt[6] = '{0, 32'h0000_0FF8, 1,   3, 2'b00, -1, 0, 0, 0, 1, 2, 0};
        vt[7] = '{1, 32'h0000_1FFC, 1,   2, 2'b00, -1, 0, 1, 0, 1, 1, 0};
`endif

        idle_inputs();
        nrst = 1'b0;
        #3;
        chk("reset_outs", 64'({xmsto.ar_valid, xmsto.aw_valid, xmsto.w_valid, xmsto.r_ready,
                               xmsto.b_ready, resp_valid, wdata_ready, req_ready}), 64'h01);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_txn(vt[i].wr, vt[i].addr, vt[i].len, vt[i].size, vt[i].resp, vt[i].err_beat,
                    vt[i].aw_delay, vt[i].gap, vt[i].bp, -1, axi_seen, nresp, nerr);
            chk($sformatf("v%0d_axi", i), 64'(axi_seen), 64'(vt[i].exp_axi));
            chk($sformatf("v%0d_nresp", i), 64'(nresp), 64'(vt[i].exp_n));
            chk($sformatf("v%0d_nerr", i), 64'(nerr), 64'(vt[i].exp_err));
        end

        // Reset mid-write burst, then a fresh read must run normally
        run_txn(1, 32'h0000_9000, 3, 3, 2'b00, -1, 0, 0, 0, 2, axi_seen, nresp, nerr);
        @(negedge clk);
        #1 chk("req_ready_post_rst", 64'(req_ready), 64'd1);
        run_txn(0, 32'h0000_A000, 1, 3, 2'b00, -1, 0, 0, 0, -1, axi_seen, nresp, nerr);
        chk("post_rst_nresp", 64'(nresp), 64'd2);
        chk("post_rst_nerr", 64'(nerr), 64'd0);

        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [31:0] a;
            int          len, size, eb, exp_err;
            logic [1:0]  resp;
            bit          lerr;
            wr   = 1'($urandom_range(0, 1));
            size = int'($urandom_range(0, 3));
            a    = ($urandom & 32'h0000_FFFF) & ~((32'd1 << size) - 32'd1);
            len  = int'($urandom_range(0, 15));
            resp = 2'($urandom_range(0, 3));
            eb   = int'($urandom_range(0, len));
            lerr = local_err(a, len, size);
            run_txn(wr, a, len, size, resp, eb, int'($urandom_range(0, 3)), 1,
                    int'($urandom_range(0, 2)), -1, axi_seen, nresp, nerr);
            exp_err = lerr ? (wr ? 1 : len + 1) : int'(resp[1]);
            chk("rnd_axi", 64'(axi_seen), 64'(!lerr));
            chk("rnd_nresp", 64'(nresp), wr ? 64'd1 : 64'(len + 1));
            chk("rnd_nerr", 64'(nerr), 64'(exp_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
